// File: rtl/wptr_full_level_if.sv
// Write-side FIFO pointer bus shared by the writer (master) and wptr_full_level (slave).
// Overflow signals wovf_clr/woverflow exist only when WPTR_OVERFLOW_EN is defined.
interface wptr_full_level_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
`ifdef WPTR_OVERFLOW_EN
  logic                wovf_clr;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wfull, walmost_full, wlevel, waddr, wptr, woverflow
  );
  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wfull, walmost_full, wlevel, waddr, wptr, woverflow
  );
`else
  modport master (
    output winc, wq2_rptr,
    input  wfull, walmost_full, wlevel, waddr, wptr
  );
  modport slave (
    input  winc, wq2_rptr,
    output wfull, walmost_full, wlevel, waddr, wptr
  );
`endif
endinterface

// File: rtl/wptr_full_level.sv
// Async-FIFO write-side pointer, full/almost-full flags and fill level.
// Optional sticky overflow flag enabled by defining WPTR_OVERFLOW_EN.
module wptr_full_level #(
  parameter int ADDRSIZE = 4,
  parameter int AFULL_TH = 2**ADDRSIZE - 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  wptr_full_level_if.slave   bus
);
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_TH);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic [ADDRSIZE:0] r_wlevel;
  logic              r_wfull;
  logic              r_walmost_full;

  logic              w_accept;
  logic [ADDRSIZE:0] w_wbinnext;
  logic [ADDRSIZE:0] w_wgraynext;
  logic [ADDRSIZE:0] w_fullcmp;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_levelnext;

  assign w_accept    = bus.winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_accept};
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
  assign w_fullcmp   = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  assign w_levelnext = w_wbinnext - w_rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wlevel       <= w_levelnext;
      r_wfull        <= (w_wgraynext == w_fullcmp);
      r_walmost_full <= (w_levelnext >= AFULL_LVL);
    end
  end

  assign bus.waddr        = r_wbin[ADDRSIZE-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wlevel       = r_wlevel;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;

`ifdef WPTR_OVERFLOW_EN
  logic r_woverflow;

  // A rejected write sets the flag; setting takes priority over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_woverflow <= 1'b0;
    end else begin
      r_woverflow <= (bus.winc & r_wfull) | (r_woverflow & ~bus.wovf_clr);
    end
  end

  assign bus.woverflow = r_woverflow;
`endif

endmodule

// File: tb/tb_wptr_full_level.sv
// Scoreboard bench for wptr_full_level: write/read totals model predicts every post-edge output.
// Overflow checks are compiled in only when WPTR_OVERFLOW_EN is defined.
module tb_wptr_full_level;
  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 2**ADDRSIZE;
  localparam int AFULL    = DEPTH - 2;

  typedef struct {
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic [4:0] wlevel;
    logic       wfull;
    logic       wafull;
    logic       wovf;
  } exp_t;

  logic wclk;
  logic wrst_n;

  wptr_full_level_if #(.ADDRSIZE(ADDRSIZE)) bus ();

  wptr_full_level #(.ADDRSIZE(ADDRSIZE), .AFULL_TH(AFULL)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Model state: total writes accepted, total entries read, last flag values.
  int   wTotal = 0;
  int   rTotal = 0;
  bit   mFull  = 1'b0;
  bit   mOvf   = 1'b0;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] toGray(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("wptr",         32'(bus.wptr),         32'(e.wptr));
    checkField("waddr",        32'(bus.waddr),        32'(e.waddr));
    checkField("wlevel",       32'(bus.wlevel),       32'(e.wlevel));
    checkField("wfull",        32'(bus.wfull),        32'(e.wfull));
    checkField("walmost_full", 32'(bus.walmost_full), 32'(e.wafull));
`ifdef WPTR_OVERFLOW_EN
    checkField("woverflow",    32'(bus.woverflow),    32'(e.wovf));
`endif
  endtask

  task automatic checkReset(input string tag);
    checkField({tag, "_wptr"},   32'(bus.wptr),         32'd0);
    checkField({tag, "_waddr"},  32'(bus.waddr),        32'd0);
    checkField({tag, "_wlevel"}, 32'(bus.wlevel),       32'd0);
    checkField({tag, "_wfull"},  32'(bus.wfull),        32'd0);
    checkField({tag, "_wafull"}, 32'(bus.walmost_full), 32'd0);
`ifdef WPTR_OVERFLOW_EN
    checkField({tag, "_wovf"},   32'(bus.woverflow),    32'd0);
`endif
  endtask

  // Drive one cycle: writer request, reader advancing by adv entries, overflow clear.
  task automatic applyStimulus(input bit winc, input int adv, input bit clr);
    exp_t e;
    bit   acc;
    int   lvl;
    @(negedge wclk);
    rTotal += adv;
    bus.winc     = winc;
    bus.wq2_rptr = toGray(rTotal);
`ifdef WPTR_OVERFLOW_EN
    bus.wovf_clr = clr;
`endif
    acc    = winc && !mFull;
    mOvf   = (winc && mFull) || (mOvf && !clr);
    wTotal += int'(acc);
    lvl    = wTotal - rTotal;
    mFull  = (lvl == DEPTH);
    e.wptr   = toGray(wTotal);
    e.waddr  = 4'(wTotal % DEPTH);
    e.wlevel = 5'(lvl);
    e.wfull  = mFull;
    e.wafull = (lvl >= AFULL);
    e.wovf   = mOvf;
    expQ.push_back(e);
  endtask

  // Monitor: compares the oldest prediction just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int avail;
    int adv;
    wrst_n       = 1'b0;
    bus.winc     = 1'b0;
    bus.wq2_rptr = '0;
`ifdef WPTR_OVERFLOW_EN
    bus.wovf_clr = 1'b0;
`endif
    #2;
    checkReset("reset");
    #10;
    wrst_n = 1'b1;

    // Fill an empty FIFO, then keep pushing while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);

    // Reader frees one slot, writer refills it, then drain to level 8.
    applyStimulus(1'b0, 1, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 8, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);

    // Asynchronous reset in the middle of a cycle at level 9.
    @(posedge wclk);
    #3;
    wrst_n       = 1'b0;
    bus.winc     = 1'b0;
    bus.wq2_rptr = '0;
    #1;
    checkReset("midreset");
    wTotal = 0;
    rTotal = 0;
    mFull  = 1'b0;
    mOvf   = 1'b0;
    #3;
    wrst_n = 1'b1;
    #1;
    checkReset("release");

    // Reader tracks two behind across a pointer rollover.
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1, 1'b0);

    // Random traffic: write-heavy phase then read-heavy phase.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 200; i++) begin
        avail = wTotal - rTotal;
        adv   = 0;
        if (avail > 0 && $urandom_range(0, 99) < (phase == 0 ? 40 : 70))
          adv = $urandom_range(1, (avail > 3) ? 3 : avail);
        applyStimulus($urandom_range(0, 99) < (phase == 0 ? 80 : 40), adv,
                      $urandom_range(0, 99) < 10);
      end
    end

    applyStimulus(1'b0, 0, 1'b0);
    repeat (3) @(posedge wclk);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/wptr_full_level.md
WPTR_FULL_LEVEL -- requirements
Module: wptr_full_level

Interface
REQ-001 Parameter ADDRSIZE, default 4, number of memory address bits; FIFO depth is 2**ADDRSIZE; legal range ADDRSIZE >= 2.
REQ-002 Parameter AFULL_TH, default 2**ADDRSIZE-2, fill level at or above which walmost_full asserts; legal range 1..2**ADDRSIZE.
REQ-003 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-004 wrst_n  input  1  asynchronous, active-low reset.
REQ-005 winc  input  1  write request.
REQ-006 wq2_rptr  input  ADDRSIZE+1  read pointer in Gray code, already synchronised into wclk.
REQ-007 wovf_clr  input  1  clears woverflow (present only with WPTR_OVERFLOW_EN).
REQ-008 wfull  output  1  FIFO full, registered.
REQ-009 walmost_full  output  1  fill level >= AFULL_TH, registered.
REQ-010 wlevel  output  ADDRSIZE+1  write-side fill level, 0..2**ADDRSIZE, registered.
REQ-011 waddr  output  ADDRSIZE  memory write address.
REQ-012 wptr  output  ADDRSIZE+1  write pointer in Gray code, registered, for the read-domain synchroniser.
REQ-013 woverflow  output  1  sticky overflow flag (present only with WPTR_OVERFLOW_EN).

Function
REQ-014 A write is accepted in a cycle when winc=1 and wfull=0; winc while wfull=1 SHALL be ignored and leave all pointers unchanged.
REQ-015 Internal binary pointer wbin (ADDRSIZE+1 bits) SHALL be wbinnext = wbin + accepted, wrapping modulo 2**(ADDRSIZE+1).
REQ-016 wptr SHALL register (wbinnext>>1) ^ wbinnext every cycle; wptr changes by exactly one bit per accepted write.
REQ-017 waddr SHALL equal wbin[ADDRSIZE-1:0], combinationally from the registered pointer.
REQ-018 wfull SHALL register (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
REQ-019 Read pointer SHALL be converted Gray-to-binary combinationally: rbin[ADDRSIZE] = g[ADDRSIZE], rbin[i] = rbin[i+1] ^ g[i].
REQ-020 wlevel SHALL register (wbinnext - rbin) modulo 2**(ADDRSIZE+1); value 2**ADDRSIZE when full.
REQ-021 walmost_full SHALL register ((wbinnext - rbin) >= AFULL_TH) using the same next-level value as wlevel.
REQ-022 Latency: an accepted write is reflected in wptr, waddr, wlevel, wfull, walmost_full one wclk edge later; a wq2_rptr change is reflected in the flags and wlevel one edge later.
REQ-023 Full and almost-full SHALL deassert conservatively only when the synchronised read pointer advances; no flag SHALL depend on any read-domain signal except wq2_rptr.
REQ-024 Wrap-around: pointer rollover from 2**(ADDRSIZE+1)-1 to 0 SHALL produce correct wfull, wlevel and walmost_full with no glitch cycle.
REQ-025 Simultaneous accepted write and read-pointer advance in the same cycle SHALL leave wlevel unchanged.

Reset
REQ-026 On wrst_n=0, wbin, wptr, wlevel SHALL clear to 0 and wfull, walmost_full, woverflow SHALL clear to 0 immediately, independent of wclk.
REQ-027 Reset asserted mid-operation SHALL abandon any in-flight write; the first write after reset release uses waddr=0.

Configuration
REQ-028 Macro WPTR_OVERFLOW_EN: when defined, wovf_clr and woverflow exist; woverflow sets on the edge after any cycle with winc=1 and wfull=1, holds until wovf_clr=1 (set wins over clear in the same cycle) or reset.
REQ-029 Without WPTR_OVERFLOW_EN, wovf_clr and woverflow SHALL be absent and no overflow logic synthesised; all other behaviour identical.

Verification
REQ-030 ADDRSIZE=4, wq2_rptr=0, 16 consecutive winc -> waddr 0..15, wlevel 1..16, walmost_full rises after write 14, wfull rises after write 16, wptr=5'b11000.
REQ-031 Full FIFO, winc held 3 cycles -> wptr, waddr, wlevel unchanged; with WPTR_OVERFLOW_EN woverflow=1 after first such edge, cleared by wovf_clr pulse.
REQ-032 Full FIFO, wq2_rptr advanced to Gray(1)=5'b00001 -> wfull=0, wlevel=15 one edge later; next winc accepted at waddr=0.
REQ-033 Drive 40 writes with reader tracking 2 behind via wq2_rptr -> wlevel constant 2, no wfull, correct rollover at pointer 31->0.
REQ-034 Assert wrst_n=0 mid-burst with wlevel=9 -> all outputs 0 asynchronously; after release first write gives waddr=0, wlevel=1.
REQ-035 Same-cycle accepted write and read advance at wlevel=8 -> wlevel stays 8, walmost_full stays 0.
